mem_arbiter: RTL and testbench

- Shares the single byte-wide memory between two requesters: the multicycle CPU controller's fetch/load/store port (port 0, "cpu") and a loader/DMA port (port 1, "dma").
- Serialises accesses through a small FSM and drives the memory strobes.
- Returns read data and a one-cycle done pulse to the winning requester.
- Uses fixed CPU priority, with a starvation limit that guarantees DMA progress.

---
 rtl/mem_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module   : mem_arbiter
// Brief    : Two-port byte-memory arbiter, fixed CPU priority with DMA starvation limit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_arbiter #(
  parameter int AW         = 8,
  parameter int DW         = 8,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic          ph1,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_done,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_gnt,
  output logic          dma_done,
  output logic [DW-1:0] dma_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_read,
  output logic          mem_write,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [LW-1:0] c_LAT_LAST   = LW'(MEM_LAT - 1);
  localparam logic [SW-1:0] c_STARVE_MAX = SW'(STARVE_MAX);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t        r_state, w_state;
  logic [LW-1:0] r_lat, w_lat;
  logic [SW-1:0] r_starve, w_starve;
  logic          r_we, w_we;
  logic          r_dma, w_dma;
  logic          w_dma_win;
  logic          w_cpu_gnt, w_dma_gnt, w_cpu_done, w_dma_done;
  logic          w_mem_read, w_mem_write, w_busy;
  logic [AW-1:0] w_mem_addr;
  logic [DW-1:0] w_mem_wdata, w_cpu_rdata, w_dma_rdata;

  assign w_dma_win = dma_req && (!cpu_req || (r_starve == c_STARVE_MAX));

  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_lat     <= '0;
      r_starve  <= '0;
      r_we      <= 1'b0;
      r_dma     <= 1'b0;
      cpu_gnt   <= 1'b0;
      dma_gnt   <= 1'b0;
      cpu_done  <= 1'b0;
      dma_done  <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rdata <= '0;
      dma_rdata <= '0;
      busy      <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_lat     <= w_lat;
      r_starve  <= w_starve;
      r_we      <= w_we;
      r_dma     <= w_dma;
      cpu_gnt   <= w_cpu_gnt;
      dma_gnt   <= w_dma_gnt;
      cpu_done  <= w_cpu_done;
      dma_done  <= w_dma_done;
      mem_read  <= w_mem_read;
      mem_write <= w_mem_write;
      mem_addr  <= w_mem_addr;
      mem_wdata <= w_mem_wdata;
      cpu_rdata <= w_cpu_rdata;
      dma_rdata <= w_dma_rdata;
      busy      <= w_busy;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_lat       = r_lat;
    w_starve    = r_starve;
    w_we        = r_we;
    w_dma       = r_dma;
    w_cpu_gnt   = cpu_gnt;
    w_dma_gnt   = dma_gnt;
    w_cpu_done  = 1'b0;
    w_dma_done  = 1'b0;
    w_mem_read  = mem_read;
    w_mem_write = mem_write;
    w_mem_addr  = mem_addr;
    w_mem_wdata = mem_wdata;
    w_cpu_rdata = cpu_rdata;
    w_dma_rdata = dma_rdata;

    case (r_state)
      S_IDLE: begin
        if (w_dma_win) begin
          w_dma       = 1'b1;
          w_we        = dma_we;
          w_mem_addr  = dma_addr;
          w_mem_wdata = dma_wdata;
          w_mem_read  = !dma_we;
          w_mem_write = dma_we;
          w_dma_gnt   = 1'b1;
          w_lat       = '0;
          w_starve    = '0;
          w_state     = S_ACCESS;
        end else if (cpu_req) begin
          w_dma       = 1'b0;
          w_we        = cpu_we;
          w_mem_addr  = cpu_addr;
          w_mem_wdata = cpu_wdata;
          w_mem_read  = !cpu_we;
          w_mem_write = cpu_we;
          w_cpu_gnt   = 1'b1;
          w_lat       = '0;
          w_state     = S_ACCESS;
          // Each CPU win while DMA waits brings the forced DMA grant closer.
          if (!dma_req)
            w_starve = '0;
          else if (r_starve != c_STARVE_MAX)
            w_starve = r_starve + 1'b1;
        end else if (!dma_req) begin
          w_starve = '0;
        end
      end

      S_ACCESS: begin
        // Writes finish in one cycle; reads wait out the memory latency.
        if (r_we || (r_lat == c_LAT_LAST)) begin
          w_mem_read  = 1'b0;
          w_mem_write = 1'b0;
          w_cpu_done  = !r_dma;
          w_dma_done  = r_dma;
          w_state     = S_DONE;
          if (!r_we) begin
            if (r_dma)
              w_dma_rdata = mem_rdata;
            else
              w_cpu_rdata = mem_rdata;
          end
        end else begin
          w_lat = r_lat + 1'b1;
        end
      end

      S_DONE: begin
        w_cpu_gnt = 1'b0;
        w_dma_gnt = 1'b0;
        w_state   = S_IDLE;
      end

      default: w_state = S_IDLE;
    endcase

    w_busy = (w_state != S_IDLE);
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Table-driven cycle checks of mem_arbiter (MEM_LAT=2, STARVE_MAX=4).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 4;

  logic       ph1 = 1'b0;
  logic       reset;
  logic       cpu_req, cpu_we, dma_req, dma_we;
  logic [7:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic       cpu_gnt, cpu_done, dma_gnt, dma_done;
  logic [7:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
  logic       mem_read, mem_write, busy;

  int n_checks = 0;
  int n_errors = 0;
  int rd_cnt = 0;
  int cpu_done_cnt = 0;
  int dma_done_cnt = 0;
  int wr_cycles = 0;
  logic [7:0] last_wa = 8'h00;
  logic [7:0] last_wd = 8'h00;

  always #5 ph1 = ~ph1;

  mem_arbiter #(.AW(8), .DW(8), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .ph1(ph1), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_done(dma_done), .dma_rdata(dma_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_rdata(mem_rdata), .busy(busy)
  );

  function automatic logic [7:0] rom(input logic [7:0] a);
    case (a)
      8'h00: rom = 8'h08;
      8'h03: rom = 8'h03;
      8'h10: rom = 8'hA5;
      8'h20: rom = 8'h11;
      8'h21: rom = 8'h22;
      8'h30: rom = 8'hC3;
      default: rom = 8'h00;
    endcase
  endfunction

  // Memory only presents valid data once the read strobe has been held MEM_LAT cycles.
  always @(posedge ph1) rd_cnt <= mem_read ? rd_cnt + 1 : 0;
  assign mem_rdata = (mem_read && rd_cnt >= MEM_LAT - 1) ? rom(mem_addr) : 8'hEE;

  always @(negedge ph1) begin
    if (cpu_done) cpu_done_cnt++;
    if (dma_done) dma_done_cnt++;
    if (mem_write) begin
      wr_cycles++;
      last_wa = mem_addr;
      last_wd = mem_wdata;
    end
  end

  wire [38:0] w_obs = {cpu_gnt, cpu_done, dma_gnt, dma_done, mem_read, mem_write, busy,
                       mem_addr, mem_wdata, cpu_rdata, dma_rdata};

  function automatic logic [38:0] eo(input logic cg, cd, dg, dd, r, w, b,
                                     input logic [7:0] ma, mw, cr, dr);
    eo = {cg, cd, dg, dd, r, w, b, ma, mw, cr, dr};
  endfunction

  typedef struct {
    string      name;
    logic       creq, cwe;
    logic [7:0] caddr, cwd;
    logic       dreq, dwe;
    logic [7:0] daddr, dwd;
    logic [38:0] exp;
  } vec_t;

  vec_t vq[$];

  task automatic add(input string nm, input logic creq, cwe, input logic [7:0] ca, cwd,
                     input logic dreq, dwe, input logic [7:0] da, dwd, input logic [38:0] e);
    vec_t v;
    v.name = nm; v.creq = creq; v.cwe = cwe; v.caddr = ca; v.cwd = cwd;
    v.dreq = dreq; v.dwe = dwe; v.daddr = da; v.dwd = dwd; v.exp = e;
    vq.push_back(v);
  endtask

  task automatic check(input string nm, input logic [38:0] got, input logic [38:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got gnt/done/rd/wr/busy=%b addr=%h wd=%h crd=%h drd=%h, want %b %h %h %h %h",
               nm, got[38:32], got[31:24], got[23:16], got[15:8], got[7:0],
               exp[38:32], exp[31:24], exp[23:16], exp[15:8], exp[7:0]);
    end
  endtask

  task automatic check_int(input string nm, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got=%0d want=%0d", nm, got, exp);
    end
  endtask

  task automatic step;
    @(posedge ph1);
    #1;
  endtask

  logic [7:0] bd [4];
  logic [7:0] prev;

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bd[0] = 8'h08; bd[1] = 8'h00; bd[2] = 8'h00; bd[3] = 8'h03;
    reset = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;

    // ---- DMA write ----
    add("dwr_acc",  0,0,8'h00,8'h00, 1,1,8'h3F,8'h5C, eo(0,0,1,0,0,1,1,8'h3F,8'h5C,8'hA5,8'h00));
    add("dwr_done", 0,0,8'h00,8'h00, 1,1,8'h3F,8'h5C, eo(0,0,1,1,0,0,1,8'h3F,8'h5C,8'hA5,8'h00));
    add("dwr_idle", 0,0,8'h00,8'h00, 0,0,8'h3F,8'h5C, eo(0,0,0,0,0,0,0,8'h3F,8'h5C,8'hA5,8'h00));
    // ---- simultaneous requests, CPU first ----
    add("sim_cg", 1,0,8'h20,8'h00, 1,0,8'h21,8'h00, eo(1,0,0,0,1,0,1,8'h20,8'h00,8'hA5,8'h00));
    add("sim_cl", 1,0,8'h20,8'h00, 1,0,8'h21,8'h00, eo(1,0,0,0,1,0,1,8'h20,8'h00,8'hA5,8'h00));
    add("sim_cd", 1,0,8'h20,8'h00, 1,0,8'h21,8'h00, eo(1,1,0,0,0,0,1,8'h20,8'h00,8'h11,8'h00));
    add("sim_ci", 0,0,8'h20,8'h00, 1,0,8'h21,8'h00, eo(0,0,0,0,0,0,0,8'h20,8'h00,8'h11,8'h00));
    add("sim_dg", 0,0,8'h20,8'h00, 1,0,8'h21,8'h00, eo(0,0,1,0,1,0,1,8'h21,8'h00,8'h11,8'h00));
    add("sim_dl", 0,0,8'h20,8'h00, 1,0,8'h21,8'h00, eo(0,0,1,0,1,0,1,8'h21,8'h00,8'h11,8'h00));
    add("sim_dd", 0,0,8'h20,8'h00, 1,0,8'h21,8'h00, eo(0,0,1,1,0,0,1,8'h21,8'h00,8'h11,8'h22));
    add("sim_di", 0,0,8'h20,8'h00, 0,0,8'h21,8'h00, eo(0,0,0,0,0,0,0,8'h21,8'h00,8'h11,8'h22));
    // ---- back-to-back IR byte fetch ----
    for (int k = 0; k < 4; k++) begin
      logic [7:0] a;
      a = 8'(k);
      prev = (k == 0) ? 8'h11 : bd[k-1];
      add("b2b_g", 1,0,a,8'h00, 0,0,8'h00,8'h00, eo(1,0,0,0,1,0,1,a,8'h00,prev,8'h22));
      add("b2b_l", 1,0,a,8'h00, 0,0,8'h00,8'h00, eo(1,0,0,0,1,0,1,a,8'h00,prev,8'h22));
      add("b2b_d", 1,0,a,8'h00, 0,0,8'h00,8'h00, eo(1,1,0,0,0,0,1,a,8'h00,bd[k],8'h22));
      add("b2b_i", (k < 3),0,(k < 3) ? a + 8'h01 : a,8'h00, 0,0,8'h00,8'h00,
          eo(0,0,0,0,0,0,0,a,8'h00,bd[k],8'h22));
    end
    // ---- req dropped after grant ----
    add("drp_g",  1,0,8'h10,8'h00, 0,0,8'h00,8'h00, eo(1,0,0,0,1,0,1,8'h10,8'h00,8'h03,8'h22));
    add("drp_l",  0,0,8'h77,8'h99, 0,0,8'h00,8'h00, eo(1,0,0,0,1,0,1,8'h10,8'h00,8'h03,8'h22));
    add("drp_d",  0,0,8'h77,8'h99, 0,0,8'h00,8'h00, eo(1,1,0,0,0,0,1,8'h10,8'h00,8'hA5,8'h22));
    add("drp_i",  0,0,8'h77,8'h99, 0,0,8'h00,8'h00, eo(0,0,0,0,0,0,0,8'h10,8'h00,8'hA5,8'h22));
    add("drp_i2", 0,0,8'h77,8'h99, 0,0,8'h00,8'h00, eo(0,0,0,0,0,0,0,8'h10,8'h00,8'hA5,8'h22));
    // ---- starvation limit: four CPU reads, then DMA is forced through ----
    for (int k = 0; k < 4; k++) begin
      prev = (k == 0) ? 8'hA5 : 8'h08;
      add("stv_cg", 1,0,8'h00,8'h00, 1,0,8'h30,8'h00, eo(1,0,0,0,1,0,1,8'h00,8'h00,prev,8'h22));
      add("stv_cl", 1,0,8'h00,8'h00, 1,0,8'h30,8'h00, eo(1,0,0,0,1,0,1,8'h00,8'h00,prev,8'h22));
      add("stv_cd", 1,0,8'h00,8'h00, 1,0,8'h30,8'h00, eo(1,1,0,0,0,0,1,8'h00,8'h00,8'h08,8'h22));
      add("stv_ci", 1,0,8'h00,8'h00, 1,0,8'h30,8'h00, eo(0,0,0,0,0,0,0,8'h00,8'h00,8'h08,8'h22));
    end
    add("stv_dg", 1,0,8'h00,8'h00, 1,0,8'h30,8'h00, eo(0,0,1,0,1,0,1,8'h30,8'h00,8'h08,8'h22));
    add("stv_dl", 1,0,8'h00,8'h00, 1,0,8'h30,8'h00, eo(0,0,1,0,1,0,1,8'h30,8'h00,8'h08,8'h22));
    add("stv_dd", 1,0,8'h00,8'h00, 1,0,8'h30,8'h00, eo(0,0,1,1,0,0,1,8'h30,8'h00,8'h08,8'hC3));
    add("stv_di", 1,0,8'h20,8'h00, 0,0,8'h30,8'h00, eo(0,0,0,0,0,0,0,8'h30,8'h00,8'h08,8'hC3));
    // Counter must have cleared on the DMA grant, so the CPU wins again.
    add("pst_cg", 1,0,8'h20,8'h00, 1,0,8'h30,8'h00, eo(1,0,0,0,1,0,1,8'h20,8'h00,8'h08,8'hC3));
    add("pst_cl", 1,0,8'h20,8'h00, 1,0,8'h30,8'h00, eo(1,0,0,0,1,0,1,8'h20,8'h00,8'h08,8'hC3));
    add("pst_cd", 1,0,8'h20,8'h00, 1,0,8'h30,8'h00, eo(1,1,0,0,0,0,1,8'h20,8'h00,8'h11,8'hC3));
    add("pst_ci", 0,0,8'h20,8'h00, 0,0,8'h30,8'h00, eo(0,0,0,0,0,0,0,8'h20,8'h00,8'h11,8'hC3));

    // ---- reset, then a read aborted by reset mid-access ----
    repeat (2) step();
    check("rst_state", w_obs, 39'h0);
    reset = 1'b0;
    cpu_req = 1'b1; cpu_addr = 8'h10;
    step(); check("abt_acc1", w_obs, eo(1,0,0,0,1,0,1,8'h10,8'h00,8'h00,8'h00));
    step(); check("abt_acc2", w_obs, eo(1,0,0,0,1,0,1,8'h10,8'h00,8'h00,8'h00));
    reset = 1'b1;
    #1 check("abt_async", w_obs, 39'h0);
    step(); check("abt_held", w_obs, 39'h0);
    reset = 1'b0;
    step(); check("rd_g", w_obs, eo(1,0,0,0,1,0,1,8'h10,8'h00,8'h00,8'h00));
    step(); check("rd_l", w_obs, eo(1,0,0,0,1,0,1,8'h10,8'h00,8'h00,8'h00));
    step(); check("rd_d", w_obs, eo(1,1,0,0,0,0,1,8'h10,8'h00,8'hA5,8'h00));
    check_int("abt_no_done", cpu_done_cnt, 0);
    cpu_req = 1'b0;
    step(); check("rd_i", w_obs, eo(0,0,0,0,0,0,0,8'h10,8'h00,8'hA5,8'h00));

    foreach (vq[i]) begin
      cpu_req = vq[i].creq; cpu_we = vq[i].cwe; cpu_addr = vq[i].caddr; cpu_wdata = vq[i].cwd;
      dma_req = vq[i].dreq; dma_we = vq[i].dwe; dma_addr = vq[i].daddr; dma_wdata = vq[i].dwd;
      step();
      check(vq[i].name, w_obs, vq[i].exp);
    end

    check_int("wr_cycles", wr_cycles, 1);
    check_int("wr_addr", int'(last_wa), 8'h3F);
    check_int("wr_data", int'(last_wd), 8'h5C);
    check_int("cpu_done_pulses", cpu_done_cnt, 12);
    check_int("dma_done_pulses", dma_done_cnt, 3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
